// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use / memory-wait hazard controller for the 5-stage core.
// Optional performance counters are enabled with the FWD_HAZARD_PERF_EN macro.
module fwd_hazard_unit #(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic                      ex_regwrite,
    input  logic                      ex_memread,
    input  logic [REG_AW-1:0]         mem_rd,
    input  logic                      mem_regwrite,
    input  logic                      mem_memop,
    input  logic                      mem_ready,
    input  logic [REG_AW-1:0]         wb_rd,
    input  logic                      wb_regwrite,
    output logic [NUM_SRC*4-1:0]      fd_mode,
    output logic                      load_use,
    output logic                      stall_if,
    output logic                      stall_id,
    output logic                      bubble_ex,
    output logic                      stall_mem,
`ifdef FWD_HAZARD_PERF_EN
    output logic [CNT_W-1:0]          perf_lu_cnt,
    output logic [CNT_W-1:0]          perf_mem_cnt,
    output logic [CNT_W-1:0]          perf_fwd_cnt,
`endif
    output logic [1:0]                hazard_state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_BUBBLE   = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t             r_state;
    logic [NUM_SRC-1:0] w_lu_hit;
    logic [NUM_SRC-1:0] w_fwd_any;
    logic               w_any_lu;
    logic               w_busy;

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_src
            logic [REG_AW-1:0] w_rs;
            logic              w_qual;
            logic              w_ex_hit;
            logic              w_mem_hit;
            logic              w_wb_hit;
            logic [3:0]        w_sel;

            assign w_rs      = id_rs[g*REG_AW +: REG_AW];
            assign w_qual    = id_rs_used[g] && (w_rs != {REG_AW{1'b0}});
            assign w_ex_hit  = w_qual && ex_regwrite && (w_rs == ex_rd) && !ex_memread;
            assign w_mem_hit = w_qual && mem_regwrite && (w_rs == mem_rd);
            assign w_wb_hit  = w_qual && wb_regwrite && (w_rs == wb_rd);
            assign w_lu_hit[g] = w_qual && ex_regwrite && (w_rs == ex_rd) && ex_memread;

            // A pending load result cannot be forwarded, so lu_hit falls back to the register file.
            assign w_sel = w_lu_hit[g] ? 4'b1000 :
                           w_ex_hit    ? 4'b0001 :
                           w_mem_hit   ? 4'b0010 :
                           w_wb_hit    ? 4'b0100 : 4'b1000;

            assign fd_mode[g*4 +: 4] = rst ? 4'b1000 : w_sel;
            assign w_fwd_any[g]      = !w_sel[3];
        end
    endgenerate

    assign w_any_lu     = |w_lu_hit;
    assign hazard_state = r_state;

    // Stall condition: in MEM_WAIT the access is outstanding until mem_ready regardless of mem_memop.
    always_comb begin
        case (r_state)
            ST_MEM_WAIT: w_busy = !mem_ready;
            default:     w_busy = mem_memop && !mem_ready;
        endcase
    end

    // Pipeline control outputs; a memory stall takes precedence over load-use.
    always_comb begin
        load_use  = 1'b0;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        bubble_ex = 1'b0;
        stall_mem = 1'b0;
        if (rst) begin
            load_use  = 1'b0;
        end else if (w_busy) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_mem = 1'b1;
        end else if (w_any_lu) begin
            load_use  = 1'b1;
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
        end else begin
            load_use  = 1'b0;
        end
    end

    // Hazard FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else if (w_busy) begin
            r_state <= ST_MEM_WAIT;
        end else if (w_any_lu) begin
            r_state <= ST_BUBBLE;
        end else begin
            r_state <= ST_RUN;
        end
    end

`ifdef FWD_HAZARD_PERF_EN
    logic [CNT_W-1:0] r_lu_cnt;
    logic [CNT_W-1:0] r_mem_cnt;
    logic [CNT_W-1:0] r_fwd_cnt;

    // Event counters, wrapping modulo 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lu_cnt  <= {CNT_W{1'b0}};
            r_mem_cnt <= {CNT_W{1'b0}};
            r_fwd_cnt <= {CNT_W{1'b0}};
        end else begin
            r_lu_cnt  <= r_lu_cnt  + {{(CNT_W-1){1'b0}}, load_use};
            r_mem_cnt <= r_mem_cnt + {{(CNT_W-1){1'b0}}, stall_mem};
            r_fwd_cnt <= r_fwd_cnt + {{(CNT_W-1){1'b0}}, |w_fwd_any};
        end
    end

    assign perf_lu_cnt  = r_lu_cnt;
    assign perf_mem_cnt = r_mem_cnt;
    assign perf_fwd_cnt = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: directed cases followed by randomized traffic.
module tb_fwd_hazard_unit;

    typedef struct packed {
        logic [7:0] fd;
        logic [4:0] ctl;   // {load_use, stall_if, stall_id, bubble_ex, stall_mem}
        logic [1:0] st;
        logic [3:0] plu;
        logic [3:0] pmem;
        logic [3:0] pfwd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    int         src [2];
    logic [1:0] used;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic       ex_regwrite, ex_memread, mem_regwrite, mem_memop, mem_ready, wb_regwrite;
    logic [9:0] id_rs;
    logic [7:0] fd_mode;
    logic       load_use, stall_if, stall_id, bubble_ex, stall_mem;
    logic [1:0] hazard_state;
`ifdef FWD_HAZARD_PERF_EN
    logic [3:0] perf_lu_cnt, perf_mem_cnt, perf_fwd_cnt;
`endif

    exp_t       q [$];
    int         m_state = 0;
    logic [3:0] c_lu = 4'd0, c_mem = 4'd0, c_fwd = 4'd0;
    int         checks = 0;
    int         errors = 0;

    assign id_rs = {5'(src[1]), 5'(src[0])};

    always #5 clk = ~clk;

    fwd_hazard_unit #(.NUM_SRC(2), .REG_AW(5), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_used(used),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memop(mem_memop),
        .mem_ready(mem_ready), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .fd_mode(fd_mode), .load_use(load_use), .stall_if(stall_if),
        .stall_id(stall_id), .bubble_ex(bubble_ex), .stall_mem(stall_mem),
`ifdef FWD_HAZARD_PERF_EN
        .perf_lu_cnt(perf_lu_cnt), .perf_mem_cnt(perf_mem_cnt), .perf_fwd_cnt(perf_fwd_cnt),
`endif
        .hazard_state(hazard_state)
    );

    // Reference model: forwarding source chosen by stage priority, then the stall decision.
    function automatic void model(output exp_t e, output int nxt);
        bit         any_lu = 1'b0;
        bit         busy;
        logic [3:0] sel;
        e = '0;
        for (int i = 0; i < 2; i++) begin
            sel = 4'b1000;
            if (!rst && used[i] && src[i] != 0) begin
                if (ex_regwrite && src[i] == int'(ex_rd)) begin
                    if (ex_memread) any_lu = 1'b1;
                    else            sel = 4'b0001;
                end else if (mem_regwrite && src[i] == int'(mem_rd)) begin
                    sel = 4'b0010;
                end else if (wb_regwrite && src[i] == int'(wb_rd)) begin
                    sel = 4'b0100;
                end
            end
            e.fd[i*4 +: 4] = sel;
        end
        busy = (m_state == 2) ? !mem_ready : (mem_memop && !mem_ready);
        nxt  = 0;
        if (!rst) begin
            e.st   = 2'(m_state);
            e.plu  = c_lu;
            e.pmem = c_mem;
            e.pfwd = c_fwd;
            if (busy) begin
                e.ctl = 5'b01101;
                nxt   = 2;
            end else if (any_lu) begin
                e.ctl = 5'b11110;
                nxt   = 1;
            end
        end
    endfunction

    task automatic step();
        exp_t e;
        int   nxt;
        model(e, nxt);
        q.push_back(e);
        @(posedge clk);
        if (rst) begin
            c_lu = 4'd0; c_mem = 4'd0; c_fwd = 4'd0; m_state = 0;
        end else begin
            c_lu    = c_lu + 4'(e.ctl[4]);
            c_mem   = c_mem + 4'(e.ctl[0]);
            c_fwd   = c_fwd + 4'(e.fd != 8'b1000_1000);
            m_state = nxt;
        end
        #1;
    endtask

    task automatic clear();
        rst = 1'b0; src[0] = 0; src[1] = 0; used = 2'b00;
        ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
        ex_regwrite = 1'b0; ex_memread = 1'b0; mem_regwrite = 1'b0;
        mem_memop = 1'b0; mem_ready = 1'b1; wb_regwrite = 1'b0;
    endtask

    // Monitor: compare the DUT against the oldest expectation, away from the rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (fd_mode !== e.fd) begin
                errors++;
                $display("FAIL fd_mode t=%0t got %b want %b", $time, fd_mode, e.fd);
            end
            checks++;
            if ({load_use, stall_if, stall_id, bubble_ex, stall_mem} !== e.ctl) begin
                errors++;
                $display("FAIL ctl t=%0t got %b want %b", $time,
                         {load_use, stall_if, stall_id, bubble_ex, stall_mem}, e.ctl);
            end
            checks++;
            if (hazard_state !== e.st) begin
                errors++;
                $display("FAIL hazard_state t=%0t got %0d want %0d", $time, hazard_state, e.st);
            end
`ifdef FWD_HAZARD_PERF_EN
            checks++;
            if ({perf_lu_cnt, perf_mem_cnt, perf_fwd_cnt} !== {e.plu, e.pmem, e.pfwd}) begin
                errors++;
                $display("FAIL perf t=%0t got %0d/%0d/%0d want %0d/%0d/%0d", $time,
                         perf_lu_cnt, perf_mem_cnt, perf_fwd_cnt, e.plu, e.pmem, e.pfwd);
            end
`endif
        end
    end

    initial begin
        clear();
        rst = 1'b1;
        @(posedge clk);
        #1;
        used = 2'b11; src[0] = 5; ex_rd = 5'd5; ex_regwrite = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        // All stages write r5: EX wins; operand 1 reads r0.
        mem_rd = 5'd5; wb_rd = 5'd5; mem_regwrite = 1'b1; wb_regwrite = 1'b1;
        step();

        // Load-use, then the load sits in MEM and is forwarded from there.
        clear(); used = 2'b01; src[0] = 7; ex_rd = 5'd7; ex_memread = 1'b1; ex_regwrite = 1'b1;
        step();
        clear(); used = 2'b01; src[0] = 7; mem_rd = 5'd7; mem_regwrite = 1'b1;
        step();

        // Memory wait with a concurrent load-use, released by mem_ready.
        clear(); used = 2'b01; src[0] = 9; ex_rd = 5'd9; ex_memread = 1'b1; ex_regwrite = 1'b1;
        mem_memop = 1'b1; mem_ready = 1'b0;
        repeat (4) step();
        mem_ready = 1'b1;
        step();
        clear();
        step();

        // Unused operand matching a load must be ignored.
        clear(); used = 2'b01; src[1] = 3; ex_rd = 5'd3; ex_memread = 1'b1; ex_regwrite = 1'b1;
        step();

        // Reset asserted in the middle of MEM_WAIT.
        clear(); mem_memop = 1'b1; mem_ready = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        clear();
        repeat (2) step();

        // Randomized traffic over a small register range so hits are frequent.
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 99) == 0);
            src[0]       = int'($urandom_range(0, 3));
            src[1]       = int'($urandom_range(0, 3));
            used         = 2'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            mem_rd       = 5'($urandom_range(0, 3));
            wb_rd        = 5'($urandom_range(0, 3));
            ex_regwrite  = 1'($urandom_range(0, 1));
            ex_memread   = ($urandom_range(0, 2) == 0);
            mem_regwrite = 1'($urandom_range(0, 1));
            wb_regwrite  = 1'($urandom_range(0, 1));
            mem_memop    = ($urandom_range(0, 2) == 0);
            mem_ready    = 1'($urandom_range(0, 1));
            step();
        end

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
